// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel edge path: collects a serial pixel stream into a
// frame, lets the Sobel datapath settle, and hands the edge map to VGA at vsync.
module sobel_frame_ctrl #(
    parameter int WIDTH  = 9,
    parameter int HEIGHT = 9,
    parameter int SETTLE = 2
) (
    input  logic                      dclk,
    input  logic                      clr,
    input  logic                      pix_valid,
    input  logic                      pix_data,
    input  logic                      pix_sof,
    output logic                      pix_ready,
    output logic [0:WIDTH*HEIGHT-1]   sob_in,
    input  logic [0:WIDTH*HEIGHT-1]   sob_out,
    input  logic                      vsync,
    output logic [0:WIDTH*HEIGHT-1]   bmp_out,
    output logic                      busy,
    output logic                      frame_done,
    output logic [7:0]                frame_count
);

    localparam int N     = WIDTH * HEIGHT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CAPTURE,
        S_WAIT_VSYNC
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   idx;
    logic [3:0]         settle_cnt;
    logic [0:N-1]       pending;
    logic               vsync_d;

    logic               can_take;
    logic               accept;
    logic               last_beat;
    logic               settle_done;
    logic               vsync_fall;

    // Ready is gated by clr so no beat is claimed as accepted in a reset cycle.
    assign can_take    = (state == S_IDLE || state == S_LOAD) && !clr;
    assign pix_ready   = can_take;
    assign accept      = pix_valid & can_take;
    assign last_beat   = (idx == IDX_W'(N - 1));
    assign settle_done = (settle_cnt == 4'(SETTLE - 1));
    assign vsync_fall  = vsync_d & ~vsync;
    assign busy        = (state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge dclk) begin
        if (clr) state <= S_IDLE;
        else     state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:       if (accept && pix_sof) next_state = S_LOAD;
            S_LOAD:       if (accept && !pix_sof && last_beat) next_state = S_SETTLE;
            S_SETTLE:     if (settle_done) next_state = S_CAPTURE;
            S_CAPTURE:    next_state = S_WAIT_VSYNC;
            S_WAIT_VSYNC: if (vsync_fall) next_state = S_IDLE;
            default:      next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge dclk) begin
        if (clr) begin
            sob_in      <= '0;
            bmp_out     <= '0;
            pending     <= '0;
            idx         <= '0;
            settle_cnt  <= '0;
            frame_done  <= 1'b0;
            frame_count <= 8'd0;
            vsync_d     <= 1'b1;
        end else begin
            vsync_d    <= vsync;
            frame_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept && pix_sof) begin
                        sob_in[0] <= pix_data;
                        idx       <= IDX_W'(1);
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (pix_sof) begin
                            sob_in[0] <= pix_data;
                            idx       <= IDX_W'(1);
                        end else begin
                            sob_in[idx] <= pix_data;
                            if (last_beat) begin
                                idx        <= '0;
                                settle_cnt <= '0;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                    end
                end
                S_SETTLE:  settle_cnt <= settle_cnt + 4'd1;
                S_CAPTURE: pending    <= sob_out;
                S_WAIT_VSYNC: begin
                    // Swap only on the vsync falling edge so the displayed frame never tears.
                    if (vsync_fall) begin
                        bmp_out     <= pending;
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sobel_frame_ctrl.md
Name: sobel_frame_ctrl

Overview:
Frame sequencer for the Sobel edge path.
- Collects a serial 1-bit pixel stream into a flattened W*H frame and drives it to the combinational Sobel datapath.
- Waits a fixed settle time, then captures the edge map.
- Hands the edge map to the VGA display only at the start of vertical sync, so the displayed bitmap never changes mid-frame.

Parameters:
WIDTH, 9, image width in pixels
HEIGHT, 9, image height in pixels
SETTLE, 2, cycles sob_in is held stable before sob_out is captured (1..15)

Ports:
dclk  in  1  clock (shared with vga)
clr  in  1  synchronous active-high reset
pix_valid  in  1  pixel beat valid
pix_data  in  1  pixel value
pix_sof  in  1  start-of-frame marker, qualified by pix_valid
pix_ready  out  1  controller accepts a beat when pix_valid&pix_ready
sob_in  out  [0:WIDTH*HEIGHT-1]  frame to Sobel inputImage (registered)
sob_out  in  [0:WIDTH*HEIGHT-1]  Sobel bmpImage result
vsync  in  1  vga vsync, active low
bmp_out  out  [0:WIDTH*HEIGHT-1]  bitmap to vga bmpInput (registered)
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse when bmp_out updates
frame_count  out  8  frames presented, wraps 255->0

Behaviour:
Reset (clr high at a dclk edge):
- state=IDLE; sob_in, bmp_out, pending register, pixel index = 0.
- frame_done=0, frame_count=0, busy=0.
- vsync_d=1, so no spurious edge is detected after reset.
- pix_ready=0 in the reset cycle.
- Reset mid-frame discards the partial frame and any pending result; bmp_out returns to 0.

FSM:
- IDLE: pix_ready=1. A beat with pix_sof=1 writes sob_in[0], sets idx=1 and moves to LOAD. Beats without pix_sof are accepted and dropped.
- LOAD: pix_ready=1. Each accepted beat writes sob_in[idx] and increments idx.
  - Accepted beat with pix_sof=1: resync; writes sob_in[0], idx=1.
  - Beat written to idx=WIDTH*HEIGHT-1 (no sof): move to SETTLE, counter=0.
  - pix_valid low: hold; no timeout.
- SETTLE: pix_ready=0, sob_in frozen. Counter increments each cycle; after SETTLE cycles, move to CAPTURE.
- CAPTURE: pending <= sob_out (one cycle), then move to WAIT_VSYNC.
- WAIT_VSYNC: pix_ready=0. vsync_d is registered every cycle in all states.
  - A falling edge (vsync_d=1 and vsync=0) detected in this state causes, at that clock edge: bmp_out <= pending, frame_done=1 for exactly that next cycle, frame_count += 1, state=IDLE.
  - An edge occurring in any other state is ignored; the controller waits for the next one.

Latency:
- Last pixel accepted at edge T: SETTLE occupies cycles T+1..T+SETTLE; CAPTURE at T+SETTLE+1; WAIT_VSYNC from T+SETTLE+2.
- bmp_out changes one cycle after the edge is sampled.

Widths and ordering:
- idx is clog2(WIDTH*HEIGHT) bits wide.
- Pixel k of the stream (raster order, row-major) maps to bit k of the [0:N-1] vector.
- sob_in bits not rewritten after a resync keep stale values until overwritten; every bit is rewritten before SETTLE.

Outputs during operation:
- bmp_out holds its last value in all states except the WAIT_VSYNC exit edge.
- busy = (state != IDLE).

Test Plan:
1. Reset, then stream 81 beats with pix_sof on beat 0 and pattern all-ones. Tie sob_out to ~sob_in in the bench. Pulse vsync low at cycle 120 -> bmp_out=81'h0 appears at cycle 121, frame_done one cycle, frame_count=1, busy falls.
2. Stream a checkerboard (bit k = k&1). Hold vsync high for 500 cycles -> state stays WAIT_VSYNC, pix_ready=0, bmp_out unchanged. Drop vsync -> bmp_out=~checkerboard next cycle.
3. Send 40 beats, then a beat with pix_sof=1, then 80 more -> frame completes after a total of 81 beats counted from the resync. sob_in bit 0 equals the resync beat's data.
4. Send 30 non-sof beats in IDLE -> all accepted with pix_ready=1, idx stays 0, busy stays 0.
5. Assert clr during LOAD at beat 50 and again during WAIT_VSYNC -> next cycle state=IDLE, bmp_out=0, frame_count=0. No frame_done on the following vsync edge.
6. Present 256 frames back-to-back -> frame_count wraps to 0. vsync edge during SETTLE ignored; bmp_out updates only on the next edge.
